// File: rtl/seq_mult_param_pkg.sv
// Shared definitions for the seq_mult_param shift-add multiplier:
// controller state encoding and the iteration-counter width helper.
package seq_mult_param_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

    // Smallest r with 2**r >= v; used as clog2(W+1) to size a counter holding W.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Controller for seq_mult_param: state register, iteration counter, busy/done,
// and the load/step/finish enables that drive the datapath in the top.
module seq_mult_ctrl
    import seq_mult_param_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic mreg_last,  // this step leaves the multiplier register empty
    output logic load,
    output logic step,
    output logic fin,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = clog2(W + 1);
    localparam logic [CW-1:0] CntInit = CW'(W);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration counter and registered done pulse; a counter of zero in RUN
    // buys the extra settle edge before FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            if (load) begin
                cnt_q <= CntInit;
            end else if (step) begin
                cnt_q <= (cnt_q == CW'(1) || mreg_last) ? '0 : cnt_q - CW'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (go) state_d = StRun;
            StRun:  if (cnt_q == '0) state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode: datapath enables and status.
    always_comb begin
        load = (state_q == StIdle) && go;
        step = (state_q == StRun) && (cnt_q != '0);
        fin  = (state_q == StFin);
        busy = (state_q != StIdle);
        done = done_q;
    end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier with go/done handshake and
// runtime signed/unsigned mode. Datapath registers live here; sequencing is in
// seq_mult_ctrl.
// Optional build macro: MULT_EARLY_EXIT_EN -- stop iterating once the
// remaining multiplier bits are all zero (product unchanged, shorter latency).
module seq_mult_param
    import seq_mult_param_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           go,
    input  logic           sgn,
    input  logic [W-1:0]   ain,
    input  logic [W-1:0]   pin,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] acc_q, mcand_q, p_q;
    logic [W-1:0]   mreg_q;
    logic           neg_q;

    logic [W-1:0]   amag, pmag;
    logic           load, step, fin, mreg_last;

    // Operand magnitudes; -2**(W-1) maps to 2**(W-1), which still fits W bits unsigned.
    always_comb begin
        amag = (sgn && ain[W-1]) ? -ain : ain;
        pmag = (sgn && pin[W-1]) ? -pin : pin;
    end

`ifdef MULT_EARLY_EXIT_EN
    assign mreg_last = (mreg_q[W-1:1] == '0);
`else
    assign mreg_last = 1'b0;
`endif

    // Datapath: load magnitudes, shift-add one multiplier bit per step, sign-fix on finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mreg_q  <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
        end else if (load) begin
            acc_q   <= '0;
            mcand_q <= {{W{1'b0}}, amag};
            mreg_q  <= pmag;
            neg_q   <= sgn & (ain[W-1] ^ pin[W-1]);
        end else if (step) begin
            if (mreg_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q <= mcand_q << 1;
            mreg_q  <= mreg_q >> 1;
        end else if (fin) begin
            p_q <= neg_q ? -acc_q : acc_q;
        end
    end

    assign p = p_q;

    seq_mult_ctrl #(
        .W (W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .mreg_last (mreg_last),
        .load      (load),
        .step      (step),
        .fin       (fin),
        .busy      (busy),
        .done      (done)
    );

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: one 8-bit and one 16-bit instance,
// compared against an arithmetic reference model of product and latency.
module tb_seq_mult_param;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        go8, sgn8, busy8, done8;
    logic [7:0]  ain8, pin8;
    logic [15:0] p8;
    logic        go16, sgn16, busy16, done16;
    logic [15:0] ain16, pin16;
    logic [31:0] p16;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.W(8)) dut8 (
        .clk (clk), .reset (reset), .go (go8), .sgn (sgn8),
        .ain (ain8), .pin (pin8), .busy (busy8), .done (done8), .p (p8)
    );

    seq_mult_param #(.W(16)) dut16 (
        .clk (clk), .reset (reset), .go (go16), .sgn (sgn16),
        .ain (ain16), .pin (pin16), .busy (busy16), .done (done16), .p (p16)
    );

    // Value of an operand as an integer under the chosen interpretation.
    function automatic longint op_val(bit wide, logic [15:0] x, bit s);
        int     w;
        longint v;
        w = wide ? 16 : 8;
        v = wide ? longint'(x) : longint'(x[7:0]);
        if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic logic [31:0] model_prod(bit wide, logic [15:0] a, logic [15:0] b, bit s);
        longint pr;
        pr = op_val(wide, a, s) * op_val(wide, b, s);
        return wide ? pr[31:0] : {16'h0, pr[15:0]};
    endfunction

    // Edges from the accepting edge to the one that raises done.
    function automatic int model_lat(bit wide, logic [15:0] b, bit s);
        int     w, hb;
        longint mag;
        w   = wide ? 16 : 8;
        mag = op_val(wide, b, s);
        if (mag < 0) mag = -mag;
        hb = 1;
        for (int i = 0; i < 16; i++) if (i < w && mag[i]) hb = i + 1;
        return (Early ? hb : w) + 2;
    endfunction

    function automatic logic rd_busy(bit wide);
        return wide ? busy16 : busy8;
    endfunction

    function automatic logic rd_done(bit wide);
        return wide ? done16 : done8;
    endfunction

    function automatic logic [31:0] rd_p(bit wide);
        return wide ? p16 : {16'h0, p8};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit wide, bit g, logic [15:0] a, logic [15:0] b, bit s);
        if (wide) begin
            go16 = g; ain16 = a; pin16 = b; sgn16 = s;
        end else begin
            go8 = g; ain8 = a[7:0]; pin8 = b[7:0]; sgn8 = s;
        end
    endtask

    // One full transaction: latency, product, busy profile, done width, hold.
    task automatic do_run(bit wide, logic [15:0] a, logic [15:0] b, bit s, string tag);
        logic [31:0] exp_p;
        int          lat, cycles;
        bit          got, busy_ok;
        exp_p   = model_prod(wide, a, b, s);
        lat     = model_lat(wide, b, s);
        got     = 1'b0;
        busy_ok = 1'b1;
        cycles  = 0;
        drive(wide, 1'b1, a, b, s);
        tick();
        drive(wide, 1'b0, 16'($urandom), 16'($urandom), ~s);
        if (rd_busy(wide) !== 1'b1) busy_ok = 1'b0;
        while (!got && cycles < 64) begin
            tick();
            cycles++;
            if (rd_done(wide) === 1'b1) got = 1'b1;
            else if (rd_busy(wide) !== 1'b1) busy_ok = 1'b0;
        end
        nvec++;
        if (!got) begin
            nerr++;
            $display("FAIL %s timeout: no done within 64 edges, required at edge %0d", tag, lat);
            return;
        end
        nvec++;
        if (cycles !== lat) begin
            nerr++;
            $display("FAIL %s latency: got %0d required %0d", tag, cycles, lat);
        end
        nvec++;
        if (rd_p(wide) !== exp_p) begin
            nerr++;
            $display("FAIL %s product a=%h b=%h s=%0d: got %h required %h",
                     tag, a, b, s, rd_p(wide), exp_p);
        end
        nvec++;
        if (!busy_ok || rd_busy(wide) !== 1'b0) begin
            nerr++;
            $display("FAIL %s busy profile: run_ok=%0d busy_at_done=%b required 1/0",
                     tag, busy_ok, rd_busy(wide));
        end
        tick();
        nvec++;
        if (rd_done(wide) !== 1'b0 || rd_p(wide) !== exp_p) begin
            nerr++;
            $display("FAIL %s after done: done=%b p=%h required done=0 p=%h",
                     tag, rd_done(wide), rd_p(wide), exp_p);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        nvec++;
        if ({busy8, done8, p8} !== 18'h0) begin
            nerr++;
            $display("FAIL reset w8: busy=%b done=%b p=%h required 0/0/0", busy8, done8, p8);
        end
        nvec++;
        if ({busy16, done16, p16} !== 34'h0) begin
            nerr++;
            $display("FAIL reset w16: busy=%b done=%b p=%h required 0/0/0", busy16, done16, p16);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        do_run(1'b0, 16'd13,   16'd11,   1'b0, "u13x11");
        do_run(1'b0, 16'h00FD, 16'd5,    1'b1, "s_m3x5");
        do_run(1'b0, 16'h0080, 16'h0080, 1'b1, "s_min_sq");
        do_run(1'b0, 16'h00FF, 16'h00FF, 1'b0, "u_max_sq");
        do_run(1'b0, 16'h007F, 16'h0080, 1'b1, "s_max_min");
        do_run(1'b0, 16'h00A5, 16'h0000, 1'b1, "zero_mult");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_run(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), "rand8");
        end
    endtask

    task automatic test_go_during_run();
        logic [31:0] exp_p;
        int          lat, cycles, extra;
        bit          got;
        exp_p  = model_prod(1'b0, 16'h2D, 16'h77, 1'b0);
        lat    = model_lat(1'b0, 16'h77, 1'b0);
        got    = 1'b0;
        extra  = 0;
        drive(1'b0, 1'b1, 16'h2D, 16'h77, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b1, 16'hFF, 16'hFF, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        cycles = 3;
        while (!got && cycles < 64) begin
            tick();
            cycles++;
            if (done8 === 1'b1) got = 1'b1;
        end
        nvec++;
        if (!got || cycles !== lat || {16'h0, p8} !== exp_p) begin
            nerr++;
            $display("FAIL go_in_run: got=%0d edge=%0d p=%h required edge=%0d p=%h",
                     got, cycles, p8, lat, exp_p);
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        nvec++;
        if (extra !== 0) begin
            nerr++;
            $display("FAIL go_in_run queued: %0d busy/done cycles after done, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        dones = 0;
        drive(1'b0, 1'b1, 16'hC3, 16'hE7, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        nvec++;
        if ({busy8, done8, p8} !== 18'h0) begin
            nerr++;
            $display("FAIL reset_mid_run: busy=%b done=%b p=%h required 0/0/0", busy8, done8, p8);
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (done8 === 1'b1) dones++;
        end
        nvec++;
        if (dones !== 0) begin
            nerr++;
            $display("FAIL reset_mid_run done: %0d pulses after abort, required 0", dones);
        end
        do_run(1'b0, 16'hC3, 16'hE7, 1'b1, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2;
        int          lat1, lat2, cycles;
        bit          got;
        exp1 = model_prod(1'b0, 16'h9A, 16'h3C, 1'b0);
        lat1 = model_lat(1'b0, 16'h3C, 1'b0);
        exp2 = model_prod(1'b0, 16'h81, 16'h7F, 1'b1);
        lat2 = model_lat(1'b0, 16'h7F, 1'b1);
        drive(1'b0, 1'b1, 16'h9A, 16'h3C, 1'b0);
        tick();
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 64) begin
            tick();
            cycles++;
            got = (done8 === 1'b1);
        end
        nvec++;
        if (cycles !== lat1 || {16'h0, p8} !== exp1) begin
            nerr++;
            $display("FAIL b2b first: edge=%0d p=%h required edge=%0d p=%h",
                     cycles, p8, lat1, exp1);
        end
        drive(1'b0, 1'b1, 16'h81, 16'h7F, 1'b1);
        tick();
        nvec++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            nerr++;
            $display("FAIL b2b restart: busy=%b done=%b required 1/0", busy8, done8);
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 64) begin
            tick();
            cycles++;
            got = (done8 === 1'b1);
        end
        nvec++;
        if (cycles !== lat2 || {16'h0, p8} !== exp2) begin
            nerr++;
            $display("FAIL b2b second: edge=%0d p=%h required edge=%0d p=%h",
                     cycles, p8, lat2, exp2);
        end
        tick();
    endtask

    task automatic test_wide();
        do_run(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "w16_max_sq");
        do_run(1'b1, 16'h8000, 16'h8000, 1'b1, "w16_min_sq");
        for (int i = 0; i < 8; i++) begin
            do_run(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "rand16");
        end
    endtask

    task automatic test_early_exit();
        do_run(1'b0, 16'd200, 16'd3, 1'b0, "early_200x3");
        do_run(1'b0, 16'd77,  16'd0, 1'b0, "early_pin0");
        do_run(1'b0, 16'h00F0, 16'h00FE, 1'b1, "early_neg2");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_go_during_run();
        test_reset_mid_run();
        test_back_to_back();
        test_wide();
        test_early_exit();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
